// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for pipe_stage_reg.
// The master modport is the environment that drives the stage's inputs and
// consumes its outputs. The slave modport is the stage itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic              i_halt;
    logic [CTRL_W-1:0] i_ctrl;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_halt;
    logic [CTRL_W-1:0] o_ctrl;
    logic [DATA_W-1:0] o_data;
    logic              o_halted;
    logic [1:0]        o_occupancy;
    logic [31:0]       o_stall_cnt;
    logic [31:0]       o_bubble_cnt;

    modport master (
        output i_flush, i_valid, i_halt, i_ctrl, i_data, i_ready,
        input  o_ready, o_valid, o_halt, o_ctrl, o_data, o_halted,
               o_occupancy, o_stall_cnt, o_bubble_cnt
    );

    modport slave (
        input  i_flush, i_valid, i_halt, i_ctrl, i_data, i_ready,
        output o_ready, o_valid, o_halt, o_ctrl, o_data, o_halted,
               o_occupancy, o_stall_cnt, o_bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with flush, halt tracking
// and optional stall/bubble performance counters.
// The main entry drives the outputs. The skid entry catches one extra entry
// when downstream stalls, so that o_ready can come straight from flops.
// Defining PIPE_STAGE_REG_PERF_EN enables the saturating counters. When the
// macro is not defined, the counter outputs are tied to zero.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    pipe_stage_reg_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic              halt;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t main_q;
    entry_t skid_q;
    logic   halt_seen_q;
    logic   halted_q;

    logic   in_xfer;
    logic   out_xfer;
    logic   ready;
    logic   load_main;
    logic   move_skid;
    logic   load_skid;
    logic   main_valid_nxt;
    logic   skid_valid_nxt;

    assign ready    = !skid_q.valid && !halt_seen_q;
    assign in_xfer  = bus.i_valid && ready;
    assign out_xfer = main_q.valid && bus.i_ready;

    // Decide where an incoming entry goes and how the two valid bits evolve.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        load_main      = 1'b0;
        move_skid      = 1'b0;
        load_skid      = 1'b0;
        main_valid_nxt = main_q.valid;
        skid_valid_nxt = skid_q.valid;
        if (!main_q.valid || (out_xfer && !skid_q.valid)) begin
            // Main is free, or it drains this cycle with nothing queued behind it.
            main_valid_nxt = in_xfer;
            load_main      = in_xfer;
        end else if (out_xfer) begin
            // The skid is full here, so ready is low and no entry can arrive.
            move_skid      = 1'b1;
            skid_valid_nxt = 1'b0;
        end else if (in_xfer) begin
            load_skid      = 1'b1;
            skid_valid_nxt = 1'b1;
        end
        if (bus.i_flush) begin
            // A flush kills held entries and any same-cycle arrival.
            // Payload flops keep their old contents.
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
            load_main      = 1'b0;
            move_skid      = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Entry storage plus the sticky halt flags.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: the payload flops are reset as well, because o_data must read 0 out of reset.
            main_q      <= '0;
            skid_q      <= '0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
            main_q.valid <= main_valid_nxt;
            skid_q.valid <= skid_valid_nxt;
            if (load_main) begin
                main_q.halt <= bus.i_halt;
                main_q.ctrl <= bus.i_ctrl;
                main_q.data <= bus.i_data;
            end else if (move_skid) begin
                main_q.halt <= skid_q.halt;
                main_q.ctrl <= skid_q.ctrl;
                main_q.data <= skid_q.data;
            end
            if (load_skid) begin
                skid_q.halt <= bus.i_halt;
                skid_q.ctrl <= bus.i_ctrl;
                skid_q.data <= bus.i_data;
            end
            if (in_xfer && bus.i_halt && !bus.i_flush) begin
                halt_seen_q <= 1'b1;
            end
            if (out_xfer && main_q.halt) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = main_q.valid;
    assign bus.o_halt      = main_q.valid ? main_q.halt : 1'b0;
    assign bus.o_ctrl      = main_q.valid ? main_q.ctrl : '0;
    assign bus.o_data      = main_q.data;
    assign bus.o_halted    = halted_q;
    assign bus.o_occupancy = {1'b0, main_q.valid} + {1'b0, skid_q.valid};

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Saturating stall and bubble counters. A flush does not affect them.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (main_q.valid && !bus.i_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bus.i_ready && !main_q.valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign bus.o_stall_cnt  = stall_cnt_q;
    assign bus.o_bubble_cnt = bubble_cnt_q;
`else
    assign bus.o_stall_cnt  = 32'd0;
    assign bus.o_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
`ifdef PIPE_STAGE_REG_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic h, input logic [7:0] c, input logic [31:0] d);
        bus.i_valid = v;
        bus.i_halt  = h;
        bus.i_ctrl  = c;
        bus.i_data  = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        cyc(); cyc();

        // Reset values
        check("rst_valid",  32'(bus.o_valid), 32'd0);
        check("rst_ready",  32'(bus.o_ready), 32'd1);
        check("rst_halt",   32'(bus.o_halt), 32'd0);
        check("rst_ctrl",   32'(bus.o_ctrl), 32'd0);
        check("rst_data",   bus.o_data, 32'd0);
        check("rst_occ",    32'(bus.o_occupancy), 32'd0);
        check("rst_halted", 32'(bus.o_halted), 32'd0);
        check("rst_stall",  bus.o_stall_cnt, 32'd0);
        check("rst_bubble", bus.o_bubble_cnt, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Streaming with downstream always ready
        bus.i_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h11, 32'd1);
        cyc();
        check("str1_valid", 32'(bus.o_valid), 32'd1);
        check("str1_data",  bus.o_data, 32'd1);
        check("str1_ctrl",  32'(bus.o_ctrl), 32'h11);
        check("str1_occ",   32'(bus.o_occupancy), 32'd1);
        drive(1'b1, 1'b0, 8'h12, 32'd2);
        cyc();
        check("str2_data",  bus.o_data, 32'd2);
        check("str2_occ",   32'(bus.o_occupancy), 32'd1);
        drive(1'b1, 1'b0, 8'h13, 32'd3);
        cyc();
        check("str3_data",  bus.o_data, 32'd3);
        check("str3_ctrl",  32'(bus.o_ctrl), 32'h13);
        check("str3_occ",   32'(bus.o_occupancy), 32'd1);
        drive(1'b0, 1'b1, 8'h55, 32'h55);
        cyc();
        check("str_bub_valid", 32'(bus.o_valid), 32'd0);
        check("str_bub_ctrl",  32'(bus.o_ctrl), 32'd0);
        check("str_bub_halt",  32'(bus.o_halt), 32'd0);
        check("str_bub_occ",   32'(bus.o_occupancy), 32'd0);

        // Backpressure fills the skid
        bus.i_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hA1, 32'hA);
        cyc();
        check("bp_a_occ",   32'(bus.o_occupancy), 32'd1);
        check("bp_a_ready", 32'(bus.o_ready), 32'd1);
        check("bp_a_data",  bus.o_data, 32'hA);
        drive(1'b1, 1'b0, 8'hB1, 32'hB);
        cyc();
        check("bp_b_occ",   32'(bus.o_occupancy), 32'd2);
        check("bp_b_ready", 32'(bus.o_ready), 32'd0);
        check("bp_b_data",  bus.o_data, 32'hA);
        drive(1'b1, 1'b0, 8'hEE, 32'hEE);
        cyc();
        check("bp_hold_occ",  32'(bus.o_occupancy), 32'd2);
        check("bp_hold_data", bus.o_data, 32'hA);
        check("bp_hold_ctrl", 32'(bus.o_ctrl), 32'hA1);
        bus.i_ready = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        cyc();
        check("bp_drain_data",  bus.o_data, 32'hB);
        check("bp_drain_ctrl",  32'(bus.o_ctrl), 32'hB1);
        check("bp_drain_occ",   32'(bus.o_occupancy), 32'd1);
        check("bp_drain_ready", 32'(bus.o_ready), 32'd1);
        cyc();
        check("bp_empty_valid", 32'(bus.o_valid), 32'd0);
        check("bp_empty_occ",   32'(bus.o_occupancy), 32'd0);

        // Flush with two held entries
        bus.i_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hE1, 32'h1E);
        cyc();
        drive(1'b1, 1'b0, 8'hF1, 32'h1F);
        cyc();
        check("fl2_occ", 32'(bus.o_occupancy), 32'd2);
        bus.i_flush = 1'b1;
        drive(1'b1, 1'b0, 8'hC1, 32'hC);
        cyc();
        check("fl2_valid", 32'(bus.o_valid), 32'd0);
        check("fl2_ctrl",  32'(bus.o_ctrl), 32'd0);
        check("fl2_occ",   32'(bus.o_occupancy), 32'd0);
        check("fl2_ready", 32'(bus.o_ready), 32'd1);
        bus.i_flush = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        cyc();
        check("fl2_after_valid", 32'(bus.o_valid), 32'd0);

        // Flush with one held entry while an accept is possible
        drive(1'b1, 1'b0, 8'h2B, 32'h2A);
        cyc();
        check("fl1_occ", 32'(bus.o_occupancy), 32'd1);
        bus.i_flush = 1'b1;
        drive(1'b1, 1'b0, 8'hC2, 32'hC2);
        cyc();
        check("fl1_valid", 32'(bus.o_valid), 32'd0);
        check("fl1_occ",   32'(bus.o_occupancy), 32'd0);
        bus.i_flush = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        cyc();
        check("fl1_after_valid", 32'(bus.o_valid), 32'd0);
        check("fl1_after_occ",   32'(bus.o_occupancy), 32'd0);

        // Asynchronous reset in the middle of a stall
        drive(1'b1, 1'b0, 8'h71, 32'h70);
        cyc();
        drive(1'b1, 1'b0, 8'h81, 32'h80);
        cyc();
        check("ar_pre_occ", 32'(bus.o_occupancy), 32'd2);
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.o_valid), 32'd0);
        check("ar_ready", 32'(bus.o_ready), 32'd1);
        check("ar_occ",   32'(bus.o_occupancy), 32'd0);
        check("ar_data",  bus.o_data, 32'd0);
        check("ar_ctrl",  32'(bus.o_ctrl), 32'd0);
        cyc();
        rst_n = 1'b1;

        // Performance counters, starting from the reset just applied
        drive(1'b1, 1'b0, 8'h91, 32'h90);
        cyc();
        check("ar_idle_data", bus.o_data, 32'h90);
        check("cnt_stall0",   bus.o_stall_cnt, 32'd0);
        drive(1'b0, 1'b0, 8'h00, 32'h0);
        repeat (5) cyc();
        check("cnt_stall5", bus.o_stall_cnt, PERF ? 32'd5 : 32'd0);
        bus.i_ready = 1'b1;
        cyc();
        check("cnt_bubble0", bus.o_bubble_cnt, 32'd0);
        repeat (3) cyc();
        check("cnt_bubble3", bus.o_bubble_cnt, PERF ? 32'd3 : 32'd0);
        check("cnt_stall_keep", bus.o_stall_cnt, PERF ? 32'd5 : 32'd0);
        bus.i_ready = 1'b0;

        // Halt entry blocks further accepts for good
        drive(1'b1, 1'b1, 8'hD1, 32'hD);
        cyc();
        check("h_ready",  32'(bus.o_ready), 32'd0);
        check("h_ohalt",  32'(bus.o_halt), 32'd1);
        check("h_data",   bus.o_data, 32'hD);
        check("h_halted", 32'(bus.o_halted), 32'd0);
        drive(1'b1, 1'b0, 8'h99, 32'h99);
        bus.i_ready = 1'b1;
        cyc();
        check("h_out_halted", 32'(bus.o_halted), 32'd1);
        check("h_out_valid",  32'(bus.o_valid), 32'd0);
        check("h_out_occ",    32'(bus.o_occupancy), 32'd0);
        bus.i_flush = 1'b1;
        cyc();
        bus.i_flush = 1'b0;
        cyc();
        check("h_ign_valid",  32'(bus.o_valid), 32'd0);
        check("h_ign_ready",  32'(bus.o_ready), 32'd0);
        check("h_ign_halted", 32'(bus.o_halted), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
